wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the duration width; it SHALL match the downstream timer.
REQ-002 Parameters T_FILL, T_WASH, T_DRAIN, T_RINSE, T_SPIN, defaults 16'd300, 16'd1200, 16'd200, 16'd600, 16'd400, SHALL set the phase durations in clock cycles.
REQ-003 clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a cycle; honoured only in IDLE.
REQ-006 prog  input  2  program select, sampled with start: 0 normal, 1 heavy, 2 quick, 3 spin-only.
REQ-007 abort  input  1  level request to abandon the cycle.
REQ-008 door_closed  input  1  start SHALL be ignored while low.
REQ-009 timer_irq  input  1  zero-reached pulse from the downstream countdown timer.
REQ-010 timer_set  output  WIDTH  duration for the phase being entered.
REQ-011 timer_load  output  1  single-cycle load strobe to the timer.
REQ-012 fill_valve, drain_pump, motor_wash, motor_spin  output  1 each  actuator enables.
REQ-013 phase  output  4  current state code; busy  output  1  high outside IDLE; done  output  1  single-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, FILL, WASH, DRAIN, RINSE_FILL, RINSE, RINSE_DRAIN, SPIN, DONE.
REQ-015 Normal: FILL→WASH→DRAIN→RINSE_FILL→RINSE→RINSE_DRAIN→SPIN→DONE with one rinse pass.
REQ-016 Heavy SHALL use twice T_WASH and two rinse passes (RINSE_DRAIN→RINSE_FILL while rinse count < 2).
REQ-017 Quick SHALL use T_WASH/2 (floor) and zero rinse passes (DRAIN→SPIN).
REQ-018 Spin-only SHALL go IDLE→DRAIN→SPIN→DONE.
REQ-019 Heavy SHALL compute 2*T_WASH in WIDTH+1 bits and saturate to all-ones when it overflows WIDTH.
REQ-020 On every entry into a timed state, the next cycle SHALL assert timer_load for exactly one cycle with timer_set holding that state's duration.
REQ-021 timer_irq SHALL be ignored in IDLE, in DONE, and in any cycle where timer_load is high.
REQ-022 In a timed state with timer_load low, timer_irq high SHALL advance the state on the next edge.
REQ-023 A duration of 0 SHALL give a phase lasting exactly 2 cycles: load, then irq.
REQ-024 Actuators: FILL and RINSE_FILL set fill_valve; WASH and RINSE set motor_wash; DRAIN and RINSE_DRAIN set drain_pump; SPIN sets motor_spin and drain_pump; all others are low.
REQ-025 Actuator outputs SHALL be registered and one-hot or zero, except that SPIN drives two.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 abort in FILL, WASH, RINSE_FILL or RINSE SHALL force DRAIN, reload T_DRAIN, and mark the cycle aborted; after that drain completes the FSM SHALL go to IDLE with no done pulse.
REQ-028 abort in DRAIN, RINSE_DRAIN or SPIN SHALL go to IDLE at the next irq without spinning further; abort in IDLE has no effect.
REQ-029 When abort and timer_irq occur in the same cycle, abort SHALL win.
REQ-030 start in a non-IDLE state SHALL be ignored; prog SHALL be latched only at an accepted start.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, rinse count 0, aborted flag 0, timer_load 0, timer_set 0, all actuators 0, busy 0, done 0.
REQ-032 Reset during any phase SHALL drop all actuators immediately, with no drain.
REQ-033 After release, the first timer_irq SHALL be ignored, because the timer's reset count may already read zero.

Structure
REQ-034 Package wash_pkg SHALL hold the state enumeration, phase codes, program codes, and the maximum rinse count constant 2.
REQ-035 The block SHALL contain no sub-module; the timer stays external and connects via timer_set, timer_load and timer_irq.

Verification (T_FILL=3, T_WASH=6, T_DRAIN=2, T_RINSE=4, T_SPIN=5, with a timer model)
REQ-036 Normal: door_closed=1, start with prog=0 → load strobes carrying 3, 6, 2, 3, 4, 2, 5 in order; done pulses once; busy drops the cycle after done.
REQ-037 Heavy: prog=1 → WASH set=12 and two RINSE_FILL/RINSE/RINSE_DRAIN passes; with T_WASH=16'hFFFF, set=16'hFFFF.
REQ-038 Quick and spin-only: prog=2 → WASH set=3 and no rinse; prog=3 → DRAIN then SPIN only.
REQ-039 Abort in WASH → next cycle drain_pump=1 with a load carrying 2; after irq, IDLE with done never asserted. Same-cycle abort and irq in FILL → DRAIN, not WASH.
REQ-040 Guards: start with door_closed=0 → stays IDLE; irq forced high during a load cycle → no advance; reset mid-SPIN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: state/phase codes, program codes and the
// actuator decode used when registering outputs.
package wash_pkg;

    localparam logic [3:0] PhaseIdle       = 4'd0;
    localparam logic [3:0] PhaseFill       = 4'd1;
    localparam logic [3:0] PhaseWash       = 4'd2;
    localparam logic [3:0] PhaseDrain      = 4'd3;
    localparam logic [3:0] PhaseRinseFill  = 4'd4;
    localparam logic [3:0] PhaseRinse      = 4'd5;
    localparam logic [3:0] PhaseRinseDrain = 4'd6;
    localparam logic [3:0] PhaseSpin       = 4'd7;
    localparam logic [3:0] PhaseDone       = 4'd8;

    typedef enum logic [3:0] {
        StIdle       = PhaseIdle,
        StFill       = PhaseFill,
        StWash       = PhaseWash,
        StDrain      = PhaseDrain,
        StRinseFill  = PhaseRinseFill,
        StRinse      = PhaseRinse,
        StRinseDrain = PhaseRinseDrain,
        StSpin       = PhaseSpin,
        StDone       = PhaseDone
    } wash_state_e;

    typedef enum logic [1:0] {
        ProgNormal = 2'd0,
        ProgHeavy  = 2'd1,
        ProgQuick  = 2'd2,
        ProgSpin   = 2'd3
    } wash_prog_e;

    localparam logic [1:0] MaxRinse = 2'd2;

    typedef struct packed {
        logic fill_valve;
        logic drain_pump;
        logic motor_wash;
        logic motor_spin;
    } act_t;

    function automatic act_t actuators(wash_state_e st);
        act_t a;
        a = '0;
        unique case (st)
            StFill, StRinseFill:  a.fill_valve = 1'b1;
            StWash, StRinse:      a.motor_wash = 1'b1;
            StDrain, StRinseDrain: a.drain_pump = 1'b1;
            StSpin: begin
                a.motor_spin = 1'b1;
                a.drain_pump = 1'b1;
            end
            default: a = '0;
        endcase
        return a;
    endfunction

    function automatic logic is_timed(wash_state_e st);
        return (st != StIdle) && (st != StDone);
    endfunction

endpackage

// File: rtl/wash_sequencer.sv
// Washing-machine phase sequencer driving an external countdown timer
// (timer_set/timer_load out, timer_irq back) and four actuator enables.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] T_FILL  = 16'd300,
    parameter logic [WIDTH-1:0] T_WASH  = 16'd1200,
    parameter logic [WIDTH-1:0] T_DRAIN = 16'd200,
    parameter logic [WIDTH-1:0] T_RINSE = 16'd600,
    parameter logic [WIDTH-1:0] T_SPIN  = 16'd400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       prog,
    input  logic             abort,
    input  logic             door_closed,
    input  logic             timer_irq,
    output logic [WIDTH-1:0] timer_set,
    output logic             timer_load,
    output logic             fill_valve,
    output logic             drain_pump,
    output logic             motor_wash,
    output logic             motor_spin,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             done
);

    wash_state_e      state_q, state_d;
    wash_prog_e       prog_q, prog_d;
    logic [1:0]       rinse_q, rinse_d;
    logic             aborted_q, aborted_d;
    logic             armed_q;
    logic             irq_ok;
    logic             load_d;
    logic [WIDTH:0]   wash_x2;
    logic [WIDTH-1:0] wash_dur, dur_d;

    // A stale zero from a freshly reset timer must not count before our first load.
    assign irq_ok  = timer_irq && !timer_load && armed_q;
    assign wash_x2 = {1'b0, T_WASH} << 1;
    assign load_d  = (state_d != state_q) && is_timed(state_d);
    assign phase   = state_q;

    always_comb begin
        unique case (prog_q)
            ProgHeavy: wash_dur = wash_x2[WIDTH] ? '1 : wash_x2[WIDTH-1:0];
            ProgQuick: wash_dur = T_WASH >> 1;
            default:   wash_dur = T_WASH;
        endcase
    end

    always_comb begin
        unique case (state_d)
            StFill, StRinseFill:   dur_d = T_FILL;
            StWash:                dur_d = wash_dur;
            StDrain, StRinseDrain: dur_d = T_DRAIN;
            StRinse:               dur_d = T_RINSE;
            StSpin:                dur_d = T_SPIN;
            default:               dur_d = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        prog_d    = prog_q;
        rinse_d   = rinse_q;
        aborted_d = aborted_q;
        unique case (state_q)
            StIdle: begin
                if (start && door_closed) begin
                    prog_d    = wash_prog_e'(prog);
                    rinse_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (wash_prog_e'(prog) == ProgSpin) ? StDrain : StFill;
                end
            end
            StFill:      state_d = abort ? StDrain : (irq_ok ? StWash : StFill);
            StWash:      state_d = abort ? StDrain : (irq_ok ? StDrain : StWash);
            StRinseFill: state_d = abort ? StDrain : (irq_ok ? StRinse : StRinseFill);
            StRinse:     state_d = abort ? StDrain : (irq_ok ? StRinseDrain : StRinse);
            StDrain: begin
                if (irq_ok) begin
                    if (abort || aborted_q) state_d = StIdle;
                    else if (prog_q == ProgQuick || prog_q == ProgSpin) state_d = StSpin;
                    else state_d = StRinseFill;
                end
            end
            StRinseDrain: begin
                if (irq_ok) begin
                    rinse_d = rinse_q + 2'd1;
                    if (abort || aborted_q) state_d = StIdle;
                    else if (prog_q == ProgHeavy && rinse_d < MaxRinse) state_d = StRinseFill;
                    else state_d = StSpin;
                end
            end
            StSpin: begin
                if (irq_ok) state_d = (abort || aborted_q) ? StIdle : StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && state_q != StIdle && state_q != StDone) aborted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prog_q     <= ProgNormal;
            rinse_q    <= '0;
            aborted_q  <= 1'b0;
            armed_q    <= 1'b0;
            timer_load <= 1'b0;
            timer_set  <= '0;
            fill_valve <= 1'b0;
            drain_pump <= 1'b0;
            motor_wash <= 1'b0;
            motor_spin <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            rinse_q    <= rinse_d;
            aborted_q  <= aborted_d;
            armed_q    <= armed_q | timer_load;
            timer_load <= load_d;
            if (load_d) timer_set <= dur_d;
            {fill_valve, drain_pump, motor_wash, motor_spin} <= actuators(state_d);
            busy       <= (state_d != StIdle);
            done       <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: timer model, load-sequence reference model per program
// with randomized programs, aborts, mid-run starts and forced irq on load cycles.
module tb_wash_sequencer;

    localparam int TF = 3, TW = 6, TD = 2, TR = 4, TS = 5;
    localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_DRAIN = 3, P_RFILL = 4;
    localparam int P_RINSE = 5, P_RDRAIN = 6, P_SPIN = 7, P_DONE = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, door_closed = 1'b1, irq_force = 1'b0;
    logic [1:0]  prog = 2'd0;
    logic        timer_irq;
    logic [15:0] timer_set;
    logic        timer_load, fill_valve, drain_pump, motor_wash, motor_spin, busy, done;
    logic [3:0]  phase;

    logic        start2 = 1'b0, irq2 = 1'b0;
    logic [15:0] set2;
    logic        load2, fv2, dp2, mw2, ms2, busy2, done2;
    logic [3:0]  phase2;

    logic [15:0] tcount;
    logic        tarmed;

    int checks = 0, failures = 0;
    int obs_ph[$], obs_set[$], exp_ph[$], exp_set[$];
    int done_cnt = 0;
    bit prev_done = 1'b0;

    always #5 clk = ~clk;

    wash_sequencer #(
        .WIDTH(16), .T_FILL(16'd3), .T_WASH(16'd6), .T_DRAIN(16'd2),
        .T_RINSE(16'd4), .T_SPIN(16'd5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog(prog), .abort(abort),
        .door_closed(door_closed), .timer_irq(timer_irq), .timer_set(timer_set),
        .timer_load(timer_load), .fill_valve(fill_valve), .drain_pump(drain_pump),
        .motor_wash(motor_wash), .motor_spin(motor_spin), .phase(phase), .busy(busy),
        .done(done)
    );

    wash_sequencer #(
        .WIDTH(16), .T_FILL(16'd3), .T_WASH(16'hFFFF), .T_DRAIN(16'd2),
        .T_RINSE(16'd4), .T_SPIN(16'd5)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .prog(2'd1), .abort(1'b0),
        .door_closed(1'b1), .timer_irq(irq2), .timer_set(set2),
        .timer_load(load2), .fill_valve(fv2), .drain_pump(dp2),
        .motor_wash(mw2), .motor_spin(ms2), .phase(phase2), .busy(busy2),
        .done(done2)
    );

    // Countdown timer: irq while armed at zero, so a zero load fires the next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcount <= '0;
            tarmed <= 1'b0;
        end else if (timer_load) begin
            tcount <= timer_set;
            tarmed <= 1'b1;
        end else if (tarmed) begin
            if (tcount == 16'd0) tarmed <= 1'b0;
            else tcount <= tcount - 16'd1;
        end
    end
    assign timer_irq = (tarmed && tcount == 16'd0) || irq_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {fill, wash, drain, spin} for a phase code.
    function automatic logic [3:0] act_of(input int ph);
        case (ph)
            P_FILL, P_RFILL:   return 4'b1000;
            P_WASH, P_RINSE:   return 4'b0100;
            P_DRAIN, P_RDRAIN: return 4'b0010;
            P_SPIN:            return 4'b0011;
            default:           return 4'b0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (timer_load) begin
            obs_ph.push_back(int'(phase));
            obs_set.push_back(int'(timer_set));
        end
        if (done) done_cnt++;
        check("actuators", 32'({fill_valve, motor_wash, drain_pump, motor_spin}),
              32'(act_of(int'(phase))));
        check("busy", 32'(busy), 32'(phase != 4'd0));
        if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
        prev_done = done;
    endtask

    // Reference: list of phases with durations; each phase lasts duration+2 cycles.
    task automatic build_exp(input int p, input int abort_at, output int exp_done);
        int ph[$];
        int du[$];
        int passes;
        int s;
        exp_ph.delete();
        exp_set.delete();
        if (p != 3) begin
            ph.push_back(P_FILL);
            du.push_back(TF);
            ph.push_back(P_WASH);
            du.push_back(p == 1 ? 2 * TW : (p == 2 ? TW / 2 : TW));
        end
        ph.push_back(P_DRAIN);
        du.push_back(TD);
        passes = (p == 0) ? 1 : ((p == 1) ? 2 : 0);
        for (int k = 0; k < passes; k++) begin
            ph.push_back(P_RFILL);  du.push_back(TF);
            ph.push_back(P_RINSE);  du.push_back(TR);
            ph.push_back(P_RDRAIN); du.push_back(TD);
        end
        ph.push_back(P_SPIN);
        du.push_back(TS);
        exp_done = 1;
        s = 1;
        for (int i = 0; i < ph.size(); i++) begin
            exp_ph.push_back(ph[i]);
            exp_set.push_back(du[i]);
            if (abort_at >= s && abort_at < s + du[i] + 2) begin
                exp_done = 0;
                if (ph[i] == P_FILL || ph[i] == P_WASH || ph[i] == P_RFILL || ph[i] == P_RINSE)
                begin
                    exp_ph.push_back(P_DRAIN);
                    exp_set.push_back(TD);
                end
                return;
            end
            s += du[i] + 2;
        end
    endtask

    task automatic run(input int p, input int abort_at, input bit force_ld);
        int  cyc;
        int  exp_done;
        bit  ab_now;
        bit  fillish;
        build_exp(p, abort_at, exp_done);
        obs_ph.delete();
        obs_set.delete();
        done_cnt = 0;
        start = 1'b1;
        prog = 2'(p);
        step();
        start = 1'b0;
        cyc = 1;
        while (phase != 4'd0 && cyc < 500) begin
            ab_now = (cyc == abort_at);
            abort = ab_now;
            irq_force = force_ld && timer_load;
            if ($urandom_range(0, 7) == 0) begin
                start = 1'b1;
                prog = 2'($urandom_range(0, 3));
            end
            fillish = (phase == 4'(P_FILL) || phase == 4'(P_WASH) ||
                       phase == 4'(P_RFILL) || phase == 4'(P_RINSE));
            step();
            abort = 1'b0;
            irq_force = 1'b0;
            start = 1'b0;
            if (ab_now && fillish)
                check($sformatf("p%0d abort_drain", p),
                      32'({phase, timer_load, drain_pump, timer_set}),
                      32'({4'(P_DRAIN), 1'b1, 1'b1, 16'(TD)}));
            cyc++;
        end
        check($sformatf("p%0d end_idle", p), 32'(phase), 32'(P_IDLE));
        check($sformatf("p%0d load_count", p), 32'(obs_ph.size()), 32'(exp_ph.size()));
        for (int i = 0; i < exp_ph.size() && i < obs_ph.size(); i++) begin
            check($sformatf("p%0d load%0d phase", p, i), 32'(obs_ph[i]), 32'(exp_ph[i]));
            check($sformatf("p%0d load%0d set", p, i), 32'(obs_set[i]), 32'(exp_set[i]));
        end
        check($sformatf("p%0d done_count", p), 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        #12;
        check("reset_outputs",
              32'({phase, busy, done, timer_load, fill_valve, drain_pump, motor_wash, motor_spin}),
              32'd0);
        check("reset_set", 32'(timer_set), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Heavy wash saturates 2*0xFFFF to 0xFFFF.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("sat_fill", 32'({phase2, load2}), 32'({4'(P_FILL), 1'b1}));
        step();
        irq2 = 1'b1;
        step();
        irq2 = 1'b0;
        check("sat_wash", 32'({phase2, load2, set2}), 32'({4'(P_WASH), 1'b1, 16'hFFFF}));

        irq_force = 1'b1;
        repeat (3) step();
        irq_force = 1'b0;
        check("stale_irq_idle", 32'(phase), 32'(P_IDLE));

        door_closed = 1'b0;
        start = 1'b1;
        prog = 2'd0;
        step();
        start = 1'b0;
        step();
        check("door_open_idle", 32'({phase, busy}), 32'd0);
        door_closed = 1'b1;

        run(0, 0, 1'b0);
        run(1, 0, 1'b0);
        run(2, 0, 1'b0);
        run(3, 0, 1'b0);
        run(0, 8, 1'b0);
        run(0, 5, 1'b0);
        run(1, 0, 1'b1);
        for (int r = 0; r < 10; r++) begin
            int p, ab;
            p = $urandom_range(0, 3);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
            run(p, ab, 1'($urandom_range(0, 1)));
        end

        // Reset mid-SPIN must clear everything without waiting for a clock edge.
        start = 1'b1;
        prog = 2'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && phase != 4'(P_SPIN); i++) step();
        check("reached_spin", 32'(phase), 32'(P_SPIN));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset",
              32'({phase, busy, done, timer_load, fill_valve, drain_pump, motor_wash, motor_spin}),
              32'd0);
        check("async_reset_set", 32'(timer_set), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        irq_force = 1'b1;
        step();
        irq_force = 1'b0;
        run(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
